// File: rtl/arbitro_pkg.sv
// Shared types and constants for the data-memory arbiter.
package arbitro_pkg;

    // Sequencer states: one cycle to select, one to access, one to acknowledge.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Requester indices as used by the grant and last_port signals.
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    // Default data memory size in bytes (256 words of 32 bits).
    localparam int MEM_BYTES_DEFAULT = 1024;

endpackage

// File: rtl/rr_arbitro2.sv
// Two-way round-robin pick: on a tie the port that was not served last wins.
module rr_arbitro2 (
    input  logic [1:0] req,
    input  logic       last_port,
    output logic       grant,
    output logic       valid
);

    // Purely combinational choice; the caller registers last_port.
    always_comb begin
        valid = |req;
        grant = 1'b0;
        if (req == 2'b11) begin
            grant = ~last_port;
        end else begin
            grant = req[1];
        end
    end

endmodule

// File: rtl/arbitro_memoria_datos.sv
// Arbiter and sequencer sharing the single-ported data memory between the
// load/store unit (port 0) and a secondary master (port 1).
//
// Handshake: a requester raises req with we/sb/lb/addr/wdata stable and holds
// it until its ack, a single-cycle pulse that also qualifies err and rdata.
// The requester drops req during the ack cycle. One access every 3 cycles.
module arbitro_memoria_datos
    import arbitro_pkg::*;
#(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic          sb0,
    input  logic          sb1,
    input  logic          lb0,
    input  logic          lb1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic          err0,
    output logic          err1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_A,
    output logic [DW-1:0] mem_WD,
    output logic          mem_MW,
    output logic          mem_SB,
    output logic          mem_loadByte,
    input  logic [DW-1:0] mem_RD,
    output logic          busy
);

    state_t        state;
    logic          last_port;
    logic          sel;
    logic          err_pending;

    logic          grant;
    logic          grant_valid;

    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_we;
    logic          sel_sb;
    logic          sel_lb;
    logic          addr_bad;
    logic [DW-1:0] rd_capture;

    rr_arbitro2 u_rr (
        .req       ({req1, req0}),
        .last_port (last_port),
        .grant     (grant),
        .valid     (grant_valid)
    );

    // Fields of whichever port the arbiter is currently picking.
    always_comb begin
        sel_addr   = (grant == PORT_AUX) ? addr1  : addr0;
        sel_wdata  = (grant == PORT_AUX) ? wdata1 : wdata0;
        sel_we     = (grant == PORT_AUX) ? we1    : we0;
        sel_sb     = (grant == PORT_AUX) ? sb1    : sb0;
        sel_lb     = (grant == PORT_AUX) ? lb1    : lb0;
        addr_bad   = (sel_addr >= AW'(MEM_BYTES));
        rd_capture = err_pending ? '0 : mem_RD;
    end

    assign busy = (state != ST_IDLE);

    // Sequencer: the memory controls are registered on selection so they are
    // valid for the whole ACCESS cycle; an async reset kills a pending write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            last_port    <= PORT_AUX;
            sel          <= PORT_CPU;
            err_pending  <= 1'b0;
            mem_A        <= '0;
            mem_WD       <= '0;
            mem_MW       <= 1'b0;
            mem_SB       <= 1'b0;
            mem_loadByte <= 1'b0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            err0         <= 1'b0;
            err1         <= 1'b0;
            rdata0       <= '0;
            rdata1       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        sel          <= grant;
                        last_port    <= grant;
                        mem_A        <= sel_addr;
                        mem_WD       <= sel_wdata;
                        err_pending  <= addr_bad;
                        mem_MW       <= sel_we & ~addr_bad;
                        mem_SB       <= sel_sb & sel_we;
                        mem_loadByte <= sel_lb & ~sel_we & ~addr_bad;
                        state        <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // The write lands on this edge; read data is captured on it too.
                    mem_MW       <= 1'b0;
                    mem_SB       <= 1'b0;
                    mem_loadByte <= 1'b0;
                    if (sel == PORT_CPU) begin
                        ack0   <= 1'b1;
                        err0   <= err_pending;
                        rdata0 <= rd_capture;
                    end else begin
                        ack1   <= 1'b1;
                        err1   <= err_pending;
                        rdata1 <= rd_capture;
                    end
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    ack0        <= 1'b0;
                    ack1        <= 1'b0;
                    err0        <= 1'b0;
                    err1        <= 1'b0;
                    rdata0      <= '0;
                    rdata1      <= '0;
                    err_pending <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_memoria_datos.sv
// Self-checking bench for arbitro_memoria_datos with a behavioural memory
// and a word-array reference model of the memory contents.
module tb_arbitro_memoria_datos;

    logic        clock;
    logic        reset_n;
    logic        req0, req1, we0, we1, sb0, sb1, lb0, lb1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_A, mem_WD, mem_RD;
    logic        mem_MW, mem_SB, mem_loadByte;
    logic        busy;

    int          checks;
    int          errors;
    logic [31:0] exp_q[$];

    logic [31:0] mem     [0:255];
    logic [31:0] seed    [0:255];
    logic [31:0] ref_mem [0:255];
    logic        preload;

    arbitro_memoria_datos #(.DW(32), .AW(32), .MEM_BYTES(1024)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req0         (req0),
        .req1         (req1),
        .we0          (we0),
        .we1          (we1),
        .sb0          (sb0),
        .sb1          (sb1),
        .lb0          (lb0),
        .lb1          (lb1),
        .addr0        (addr0),
        .addr1        (addr1),
        .wdata0       (wdata0),
        .wdata1       (wdata1),
        .ack0         (ack0),
        .ack1         (ack1),
        .err0         (err0),
        .err1         (err1),
        .rdata0       (rdata0),
        .rdata1       (rdata1),
        .mem_A        (mem_A),
        .mem_WD       (mem_WD),
        .mem_MW       (mem_MW),
        .mem_SB       (mem_SB),
        .mem_loadByte (mem_loadByte),
        .mem_RD       (mem_RD),
        .busy         (busy)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- memory model (memoriaDatos behaviour) ----------------
    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= seed[i];
        end else if (mem_MW) begin
            if (mem_SB) mem[mem_A[9:2]][7:0] <= mem_WD[7:0];
            else        mem[mem_A[9:2]]      <= mem_WD;
        end
    end

    always @(negedge clock) begin
        if (mem_loadByte) mem_RD <= {24'h0, mem[mem_A[9:2]][7:0]};
        else              mem_RD <= mem[mem_A[9:2]];
    end

    // ---------------- reference model ----------------
    task automatic ref_access(input logic we, input logic sb, input logic lb,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] exp_rd, output logic exp_err);
        logic [31:0] old;
        int idx;
        if (addr >= 32'd1024) begin
            exp_err = 1'b1;
            exp_rd  = 32'h0;
        end else begin
            idx     = int'(addr / 4);
            old     = ref_mem[idx];
            exp_err = 1'b0;
            if (we) begin
                if (sb) ref_mem[idx] = {old[31:8], wdata[7:0]};
                else    ref_mem[idx] = wdata;
                exp_rd = old;
            end else begin
                exp_rd = lb ? (old & 32'hFF) : old;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; sb0 = 0; sb1 = 0; lb0 = 0; lb1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    // One access on one port; returns what was observed at the ack.
    task automatic do_access(input logic port, input logic we, input logic sb, input logic lb,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rd, output logic er, output int lat,
                             output int mw_cnt, output logic [32:0] other);
        logic got;
        rd = '0; er = 1'b0; other = '0; lat = 0; mw_cnt = 0; got = 1'b0;
        @(posedge clock);
        #1;
        if (port) begin
            we1 = we; sb1 = sb; lb1 = lb; addr1 = addr; wdata1 = wdata; req1 = 1'b1;
        end else begin
            we0 = we; sb0 = sb; lb0 = lb; addr0 = addr; wdata0 = wdata; req0 = 1'b1;
        end
        while (!got && lat < 10) begin
            @(negedge clock);
            lat++;
            if (mem_MW) mw_cnt++;
            if (port ? ack1 : ack0) begin
                got   = 1'b1;
                rd    = port ? rdata1 : rdata0;
                er    = port ? err1 : err0;
                other = port ? {ack0, rdata0} : {ack1, rdata1};
            end
        end
        if (port) req1 = 1'b0; else req0 = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clock);
        checks++;
        if ({ack0, ack1, err0, err1, rdata0, rdata1, mem_A, mem_WD,
             mem_MW, mem_SB, mem_loadByte, busy} !== 136'h0) begin
            errors++;
            $display("FAIL reset_in_reset: outputs=%h required all zero",
                     {ack0, ack1, err0, err1, rdata0, rdata1, mem_A, mem_WD,
                      mem_MW, mem_SB, mem_loadByte, busy});
        end
    endtask

    task automatic test_single_store();
        logic [31:0] rd, exp_rd; logic er, exp_err; int lat, mw; logic [32:0] oth;
        ref_access(1, 0, 0, 32'h10, 32'hDEADBEEF, exp_rd, exp_err);
        do_access(0, 1, 0, 0, 32'h10, 32'hDEADBEEF, rd, er, lat, mw, oth);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL store_latency: got %0d required 3", lat); end
        checks++;
        if (mw !== 1) begin errors++; $display("FAIL store_mw_cycles: got %0d required 1", mw); end
        checks++;
        if (er !== exp_err) begin errors++; $display("FAIL store_err: got %b required %b", er, exp_err); end
        ref_access(0, 0, 0, 32'h10, 32'h0, exp_rd, exp_err);
        do_access(1, 0, 0, 0, 32'h10, 32'h0, rd, er, lat, mw, oth);
        checks++;
        if (rd !== 32'hDEADBEEF || rd !== exp_rd) begin
            errors++; $display("FAIL load_after_store: got %h required %h", rd, 32'hDEADBEEF);
        end
        checks++;
        if (lat !== 3 || mw !== 0) begin
            errors++; $display("FAIL load_timing: lat %0d mw %0d required 3 and 0", lat, mw);
        end
    endtask

    task automatic test_byte();
        logic [31:0] rd, exp_rd; logic er, exp_err; int lat, mw; logic [32:0] oth;
        ref_access(1, 0, 0, 32'h20, 32'h11223344, exp_rd, exp_err);
        do_access(0, 1, 0, 0, 32'h20, 32'h11223344, rd, er, lat, mw, oth);
        ref_access(1, 1, 0, 32'h20, 32'h000000A5, exp_rd, exp_err);
        do_access(1, 1, 1, 0, 32'h20, 32'h000000A5, rd, er, lat, mw, oth);
        ref_access(0, 0, 0, 32'h20, 32'h0, exp_rd, exp_err);
        do_access(1, 0, 0, 0, 32'h20, 32'h0, rd, er, lat, mw, oth);
        checks++;
        if (rd !== 32'h112233A5 || rd !== exp_rd) begin
            errors++; $display("FAIL sb_word_read: got %h required %h", rd, 32'h112233A5);
        end
        ref_access(0, 0, 1, 32'h20, 32'h0, exp_rd, exp_err);
        do_access(0, 0, 0, 1, 32'h20, 32'h0, rd, er, lat, mw, oth);
        checks++;
        if (rd !== 32'h000000A5 || rd !== exp_rd) begin
            errors++; $display("FAIL lb_read: got %h required %h", rd, 32'h000000A5);
        end
    endtask

    task automatic test_contention();
        logic [31:0] a0, a1, rd, exp_rd;
        int cyc, prev, grants, n0, n1;
        logic re0, re1, p;
        apply_reset();
        a0 = $urandom_range(0, 255) * 4;
        a1 = $urandom_range(0, 255) * 4;
        @(posedge clock);
        #1;
        we0 = 0; we1 = 0; sb0 = 0; sb1 = 0; lb0 = 0; lb1 = 0;
        addr0 = a0; addr1 = a1; req0 = 1; req1 = 1;
        cyc = 0; prev = 0; grants = 0; n0 = 0; n1 = 0; re0 = 0; re1 = 0;
        while (grants < 4 && cyc < 60) begin
            @(negedge clock);
            cyc++;
            checks++;
            if (ack0 && ack1) begin errors++; $display("FAIL ack_exclusive: both acks high at cycle %0d", cyc); end
            if (ack0 || ack1) begin
                p = ack1;
                exp_rd = p ? ref_mem[a1 / 4] : ref_mem[a0 / 4];
                rd = p ? rdata1 : rdata0;
                checks++;
                if (p !== grants[0]) begin
                    errors++; $display("FAIL grant_order: grant %0d went to port %0d required %0d", grants, p, grants[0]);
                end
                checks++;
                if (rd !== exp_rd) begin errors++; $display("FAIL contention_rdata: got %h required %h", rd, exp_rd); end
                if (grants > 0) begin
                    checks++;
                    if (cyc - prev !== 3) begin
                        errors++; $display("FAIL ack_spacing: got %0d cycles required 3", cyc - prev);
                    end
                end
                prev = cyc;
                grants++;
                if (p) begin req1 = 0; n1++; re1 = (n1 < 2); end
                else   begin req0 = 0; n0++; re0 = (n0 < 2); end
            end
            @(posedge clock);
            #1;
            if (re0) begin req0 = 1; re0 = 0; end
            if (re1) begin req1 = 1; re1 = 0; end
        end
        checks++;
        if (grants !== 4) begin errors++; $display("FAIL contention_grants: got %0d required 4", grants); end
        idle_inputs();
        repeat (3) @(posedge clock);
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd, exp_rd, w0; logic er, exp_err; int lat, mw; logic [32:0] oth;
        w0 = ref_mem[0];
        ref_access(1, 0, 0, 32'h400, 32'h5A5A5A5A, exp_rd, exp_err);
        do_access(0, 1, 0, 0, 32'h400, 32'h5A5A5A5A, rd, er, lat, mw, oth);
        checks++;
        if (er !== 1'b1 || lat !== 3) begin errors++; $display("FAIL oor_err: err %b lat %0d required 1 and 3", er, lat); end
        checks++;
        if (mw !== 0) begin errors++; $display("FAIL oor_mw: got %0d write cycles required 0", mw); end
        @(negedge clock);
        checks++;
        if (mem[0] !== w0) begin errors++; $display("FAIL oor_word0: got %h required %h", mem[0], w0); end
        ref_access(0, 0, 0, 32'hFFFFFFFC, 32'h0, exp_rd, exp_err);
        do_access(1, 0, 0, 0, 32'hFFFFFFFC, 32'h0, rd, er, lat, mw, oth);
        checks++;
        if (er !== exp_err || rd !== exp_rd) begin
            errors++; $display("FAIL oor_load: err %b rdata %h required %b %h", er, rd, exp_err, exp_rd);
        end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] old;
        old = ref_mem[12];
        @(posedge clock);
        #1;
        we0 = 1; sb0 = 0; lb0 = 0; addr0 = 32'h30; wdata0 = ~old; req0 = 1;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (mem_MW !== 1'b1) begin errors++; $display("FAIL rst_mid_mw_before: got %b required 1", mem_MW); end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({ack0, ack1, err0, err1, rdata0, rdata1, mem_A, mem_WD,
             mem_MW, mem_SB, mem_loadByte, busy} !== 136'h0) begin
            errors++; $display("FAIL rst_mid_outputs: mem_MW=%b busy=%b mem_A=%h required all zero", mem_MW, busy, mem_A);
        end
        req0 = 0;
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (mem[12] !== old) begin errors++; $display("FAIL rst_mid_word: got %h required %h", mem[12], old); end
        idle_inputs();
    endtask

    task automatic test_idle();
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            checks++;
            if ({busy, mem_MW, mem_SB, mem_loadByte} !== 4'b0) begin
                errors++; $display("FAIL idle_quiet: busy/MW/SB/LB=%b required 0000 at cycle %0d",
                                   {busy, mem_MW, mem_SB, mem_loadByte}, i);
            end
        end
    endtask

    task automatic test_back_to_back_random();
        logic [31:0] rd, exp_rd, addr, wdata, exp_pop; logic er, exp_err; int lat, mw;
        logic [32:0] oth; logic port, we, sb, lb;
        for (int i = 0; i < 40; i++) begin
            port  = 1'($urandom_range(0, 1));
            we    = 1'($urandom_range(0, 1));
            sb    = 1'($urandom_range(0, 1));
            lb    = 1'($urandom_range(0, 1));
            wdata = $urandom;
            if ($urandom_range(0, 7) == 0) addr = 32'h400 + $urandom_range(0, 32'hFFFF);
            else                           addr = $urandom_range(0, 1023);
            ref_access(we, sb, lb, addr, wdata, exp_rd, exp_err);
            exp_q.push_back(exp_rd);
            do_access(port, we, sb, lb, addr, wdata, rd, er, lat, mw, oth);
            exp_pop = exp_q.pop_front();
            checks++;
            if (rd !== exp_pop || er !== exp_err || lat !== 3) begin
                errors++;
                $display("FAIL rand_access[%0d]: rdata %h err %b lat %0d required %h %b 3 (port %0d we %b addr %h)",
                         i, rd, er, lat, exp_pop, exp_err, port, we, addr);
            end
            checks++;
            if (mw !== ((we && !exp_err) ? 1 : 0) || oth !== 33'h0) begin
                errors++;
                $display("FAIL rand_side[%0d]: mw_cycles %0d other %h required %0d and 0",
                         i, mw, oth, (we && !exp_err) ? 1 : 0);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) begin
            seed[i]    = $urandom;
            ref_mem[i] = seed[i];
        end
        preload = 1'b1;
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        test_reset();
        @(posedge clock);
        #1 reset_n = 1'b1;
        preload = 1'b0;
        test_reset();
        test_single_store();
        test_byte();
        test_contention();
        test_out_of_range();
        test_reset_mid_access();
        test_idle();
        test_back_to_back_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
